// File: rtl/mem_stage_if.sv
// Data-memory request/done bus between the memory stage and data memory.
//
// Handshake: the master raises mem_req together with mem_wr, mem_addr and
// mem_wdata and holds all four stable until the slave returns a single-cycle
// mem_done pulse. mem_rdata is valid only in the mem_done cycle. The master
// drops mem_req on the edge that samples mem_done. A mem_done seen while
// mem_req is low has no effect.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_done
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 16-bit five-stage pipeline: multi-cycle load/store
// over a request/done bus, pipeline stall while an access is outstanding,
// branch/jump redirect, and sticky halt / error tracking.
module mem_stage #(
    parameter int unsigned TIMEOUT     = 16,   // 2..255 BUSY cycles before abort
    parameter bit          ALIGN_CHECK = 1'b1  // odd word address raises err
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [15:0] alu_in,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_wrt,
    input  logic        halt_in,
    input  logic        branch_take,
    input  logic        pc_or_add,
    input  logic        alu_jmp,
    input  logic [15:0] sgn_ext,
    input  logic [15:0] pc2,
    mem_stage_if.master mem,
    output logic [15:0] read_data,
    output logic        stall,
    output logic        pc_redirect,
    output logic [15:0] new_pc,
    output logic        err,
    output logic        halt_out,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        access;
    logic        unaligned;
    logic [15:0] pc_target;

    // An error freezes the memory side: no further accesses until reset.
    assign access    = valid & (mem_read | mem_wrt) & ~err;
    assign unaligned = ALIGN_CHECK & alu_in[0];
    assign dbg_state = state;

    // Stall upstream while a request is about to be issued or is outstanding;
    // DONE releases the pipeline so the same instruction moves on.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = access & ~unaligned;
            BUSY:    stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Redirect target: register jump, PC-relative jump/branch, or fall-through.
    always_comb begin
        pc_target = pc2 + sgn_ext;
        if (alu_jmp)
            new_pc = alu_in;
        else if (branch_take | pc_or_add)
            new_pc = pc_target;
        else
            new_pc = pc2;
        pc_redirect = valid & ~stall & (alu_jmp | branch_take | pc_or_add);
    end

    // Access FSM, request bus registers, load capture and sticky error/halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_addr  <= 16'h0000;
            mem.mem_wdata <= 16'h0000;
            read_data     <= 16'h0000;
            err           <= 1'b0;
            halt_out      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (unaligned) begin
                            err      <= 1'b1;
                            halt_out <= 1'b1;
                        end else begin
                            mem.mem_addr  <= alu_in;
                            mem.mem_wdata <= write_data;
                            mem.mem_wr    <= mem_wrt;
                            mem.mem_req   <= 1'b1;
                            cnt           <= 8'd0;
                            state         <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Completion beats a timeout landing in the same cycle.
                    if (mem.mem_done) begin
                        if (!mem.mem_wr)
                            read_data <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        cnt         <= 8'd0;
                        state       <= DONE;
                    end else if (cnt == TMO_LAST) begin
                        err         <= 1'b1;
                        halt_out    <= 1'b1;
                        read_data   <= 16'h0000;
                        mem.mem_req <= 1'b0;
                        cnt         <= 8'd0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Never issue from here: the instruction in EX/MEM is
                    // still the one that just completed.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (valid & halt_in & ~stall)
                halt_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, alignment error, timeout,
// redirect and reset-during-access, with hand-computed expectations.
module tb_mem_stage;

    localparam logic [1:0] S_IDLE = 2'd0;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] alu_in;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_wrt;
    logic        halt_in;
    logic        branch_take;
    logic        pc_or_add;
    logic        alu_jmp;
    logic [15:0] sgn_ext;
    logic [15:0] pc2;
    logic [15:0] read_data;
    logic        stall;
    logic        pc_redirect;
    logic [15:0] new_pc;
    logic        err;
    logic        halt_out;
    logic [1:0]  dbg_state;

    mem_stage_if mem ();

    mem_stage #(.TIMEOUT(4), .ALIGN_CHECK(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .alu_in     (alu_in),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_wrt    (mem_wrt),
        .halt_in    (halt_in),
        .branch_take(branch_take),
        .pc_or_add  (pc_or_add),
        .alu_jmp    (alu_jmp),
        .sgn_ext    (sgn_ext),
        .pc2        (pc2),
        .mem        (mem),
        .read_data  (read_data),
        .stall      (stall),
        .pc_redirect(pc_redirect),
        .new_pc     (new_pc),
        .err        (err),
        .halt_out   (halt_out),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    int n_stall;
    int n_busy;
    logic [15:0] snap_addr;
    logic [15:0] snap_wdata;
    logic        snap_wr;
    int rises_before;

    always @(posedge mem.mem_req) req_rises++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        valid = 1'b0; alu_in = 16'h0; write_data = 16'h0;
        mem_read = 1'b0; mem_wrt = 1'b0; halt_in = 1'b0;
        branch_take = 1'b0; pc_or_add = 1'b0; alu_jmp = 1'b0;
        sgn_ext = 16'h0; pc2 = 16'h0;
        mem.mem_done = 1'b0; mem.mem_rdata = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Present one load/store and play the memory side: mem_done is pulsed in
    // the done_at-th cycle mem_req is seen high (0 = never). Returns in DONE.
    task automatic run_access(input logic [15:0] addr, input logic [15:0] wdata,
                              input logic is_wr, input int done_at,
                              input logic [15:0] rdata);
        valid = 1'b1; alu_in = addr; write_data = wdata;
        mem_read = ~is_wr; mem_wrt = is_wr;
        n_stall = 0; n_busy = 0;
        #1;
        while (stall && n_stall < 40) begin
            n_stall++;
            if (mem.mem_req) begin
                n_busy++;
                if (n_busy == 1) begin
                    snap_addr = mem.mem_addr; snap_wr = mem.mem_wr; snap_wdata = mem.mem_wdata;
                end
                if (n_busy == done_at) begin
                    mem.mem_done = 1'b1; mem.mem_rdata = rdata;
                end
            end
            @(negedge clk);
            mem.mem_done = 1'b0; mem.mem_rdata = 16'h0;
            #1;
        end
        check("access_bound", {31'b0, stall}, 32'd0);
    endtask

    task automatic end_access();
        valid = 1'b0; mem_read = 1'b0; mem_wrt = 1'b0; alu_jmp = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // reset state
        check("rst_mem_req",   {31'b0, mem.mem_req}, 32'd0);
        check("rst_mem_wr",    {31'b0, mem.mem_wr}, 32'd0);
        check("rst_mem_addr",  {16'b0, mem.mem_addr}, 32'h0);
        check("rst_mem_wdata", {16'b0, mem.mem_wdata}, 32'h0);
        check("rst_read_data", {16'b0, read_data}, 32'h0);
        check("rst_err",       {31'b0, err}, 32'd0);
        check("rst_halt",      {31'b0, halt_out}, 32'd0);
        check("rst_stall",     {31'b0, stall}, 32'd0);
        check("rst_redirect",  {31'b0, pc_redirect}, 32'd0);
        check("rst_state",     {30'b0, dbg_state}, {30'b0, S_IDLE});

        // load, mem_done in 3rd BUSY cycle
        rises_before = req_rises;
        run_access(16'h0040, 16'h0, 1'b0, 3, 16'hBEEF);
        check("ld_stall_cycles", n_stall, 32'd4);
        check("ld_mem_addr",     {16'b0, snap_addr}, 32'h0040);
        check("ld_mem_wr",       {31'b0, snap_wr}, 32'd0);
        check("ld_read_data",    {16'b0, read_data}, 32'hBEEF);
        check("ld_req_dropped",  {31'b0, mem.mem_req}, 32'd0);
        check("ld_req_rises",    req_rises - rises_before, 32'd1);
        end_access();
        check("ld_back_idle",    {30'b0, dbg_state}, {30'b0, S_IDLE});
        check("ld_no_reissue",   req_rises - rises_before, 32'd1);

        // store, mem_done in 1st BUSY cycle; read_data must keep the load value
        run_access(16'h0102, 16'h1234, 1'b1, 1, 16'h7777);
        check("st_stall_cycles", n_stall, 32'd2);
        check("st_mem_addr",     {16'b0, snap_addr}, 32'h0102);
        check("st_mem_wr",       {31'b0, snap_wr}, 32'd1);
        check("st_mem_wdata",    {16'b0, snap_wdata}, 32'h1234);
        check("st_read_data",    {16'b0, read_data}, 32'hBEEF);
        end_access();

        // timeout: no mem_done at all
        run_access(16'h0080, 16'h0, 1'b0, 0, 16'h0);
        check("tmo_stall_cycles", n_stall, 32'd5);
        check("tmo_err",          {31'b0, err}, 32'd1);
        check("tmo_halt",         {31'b0, halt_out}, 32'd1);
        check("tmo_read_data",    {16'b0, read_data}, 32'h0);
        check("tmo_req_dropped",  {31'b0, mem.mem_req}, 32'd0);
        end_access();

        // mem_done in the same cycle the timeout would fire
        do_reset();
        run_access(16'h0080, 16'h0, 1'b0, 4, 16'h5A5A);
        check("tmo_edge_stall",   n_stall, 32'd5);
        check("tmo_edge_err",     {31'b0, err}, 32'd0);
        check("tmo_edge_rdata",   {16'b0, read_data}, 32'h5A5A);
        end_access();

        // unaligned load
        do_reset();
        rises_before = req_rises;
        run_access(16'h0003, 16'h0, 1'b0, 0, 16'h0);
        check("ua_stall",   n_stall, 32'd0);
        check("ua_no_req",  {31'b0, mem.mem_req}, 32'd0);
        @(negedge clk); #1;
        check("ua_err",     {31'b0, err}, 32'd1);
        check("ua_halt",    {31'b0, halt_out}, 32'd1);
        alu_in = 16'h0040;
        #1;
        check("ua_blocked_stall", {31'b0, stall}, 32'd0);
        @(negedge clk); #1;
        check("ua_blocked_req",   {31'b0, mem.mem_req}, 32'd0);
        check("ua_req_rises",     req_rises - rises_before, 32'd0);
        end_access();

        // redirects
        do_reset();
        valid = 1'b1; branch_take = 1'b1; pc2 = 16'hFFFE; sgn_ext = 16'h0004;
        #1;
        check("br_redirect", {31'b0, pc_redirect}, 32'd1);
        check("br_new_pc",   {16'b0, new_pc}, 32'h0002);
        branch_take = 1'b0; pc_or_add = 1'b1; pc2 = 16'h0010; sgn_ext = 16'hFFF0;
        #1;
        check("j_new_pc",    {16'b0, new_pc}, 32'h0000);
        pc_or_add = 1'b0; alu_jmp = 1'b1; alu_in = 16'h0200;
        #1;
        check("jr_redirect", {31'b0, pc_redirect}, 32'd1);
        check("jr_new_pc",   {16'b0, new_pc}, 32'h0200);
        alu_jmp = 1'b0; pc2 = 16'h0124;
        #1;
        check("seq_redirect", {31'b0, pc_redirect}, 32'd0);
        check("seq_new_pc",   {16'b0, new_pc}, 32'h0124);
        valid = 1'b0; alu_jmp = 1'b1;
        #1;
        check("inv_redirect", {31'b0, pc_redirect}, 32'd0);
        // jump carried by a load: suppressed while stalled, taken in DONE
        mem_read = 1'b1; valid = 1'b1;
        #1;
        check("jr_stall_redirect", {31'b0, pc_redirect}, 32'd0);
        run_access(16'h0200, 16'h0, 1'b0, 2, 16'h0F0F);
        check("jr_done_redirect", {31'b0, pc_redirect}, 32'd1);
        check("jr_done_new_pc",   {16'b0, new_pc}, 32'h0200);
        end_access();

        // halt
        valid = 1'b1; halt_in = 1'b1;
        @(negedge clk); #1;
        valid = 1'b0; halt_in = 1'b0;
        check("halt_set", {31'b0, halt_out}, 32'd1);
        check("halt_err", {31'b0, err}, 32'd0);
        @(negedge clk); #1;
        check("halt_sticky", {31'b0, halt_out}, 32'd1);

        // reset while BUSY, stale mem_done afterwards
        do_reset();
        run_access(16'h0040, 16'h0, 1'b0, 1, 16'h1111);
        check("pre_rst_rdata", {16'b0, read_data}, 32'h1111);
        end_access();
        valid = 1'b1; mem_read = 1'b1; alu_in = 16'h0044;
        repeat (2) @(negedge clk);
        #1;
        check("mid_busy_req", {31'b0, mem.mem_req}, 32'd1);
        rst = 1'b1; valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem.mem_done = 1'b1; mem.mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem.mem_done = 1'b0; mem.mem_rdata = 16'h0;
        #1;
        check("rstb_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
        check("rstb_req",   {31'b0, mem.mem_req}, 32'd0);
        check("rstb_rdata", {16'b0, read_data}, 32'h0);
        check("rstb_stall", {31'b0, stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
